// File: rtl/core_if_ibuf.sv
// core_if_ibuf: instruction fetch buffer that pairs in-order L1I words with their PCs for decode.
// Latency: PC to L1I is combinational; an L1I response becomes visible on dec_* one cycle later.
// Backpressure: fetch is stalled while queued + outstanding + dropping slots reach DEPTH.
//
// Ports:
//   clk, rst            core clock, synchronous active-high reset
//   ibuf_req_*          fetch-stage PC request; ibuf_req_rdy_out doubles as the fetch advance enable
//   ibuf_kill_in        redirect flush: discard queued and in-flight instructions
//   l1i_req_*           request to the L1I (valid/ack handshake, address passes straight through)
//   l1i_resp_*          instruction words returned by the L1I in request order
//   dec_*               show-ahead {instr, pc, pc+4} head entry to decode (valid/ready)
module core_if_ibuf #(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ibuf_req_val_in,
  input  logic [31:0] ibuf_req_pc_in,
  output logic        ibuf_req_rdy_out,
  input  logic        ibuf_kill_in,
  output logic        l1i_req_val_out,
  output logic [31:0] l1i_req_addr_out,
  input  logic        l1i_req_ack_in,
  input  logic        l1i_resp_val_in,
  input  logic [31:0] l1i_resp_data_in,
  output logic        dec_val_out,
  output logic [31:0] dec_instr_out,
  output logic [31:0] dec_pc_out,
  output logic [31:0] dec_pc_4_out,
  input  logic        dec_rdy_in
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int OCC_W = CNT_W + 2;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc_4;
  } ibuf_ent_t;

  // ---------------------------------------------------------------------------
  // Occupancy and credit
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0] pend_cnt;
  logic [CNT_W-1:0] ifq_cnt;
  logic [CNT_W-1:0] drop_cnt;
  logic [OCC_W-1:0] occ;
  logic             credit_ok;

  // Every slot is accounted for from the moment its request is acked until
  // decode consumes it (or its response is discarded), so the ifq can never
  // overflow and the L1I never returns more words than pend/drop can absorb.
  assign occ       = OCC_W'(ifq_cnt) + OCC_W'(pend_cnt) + OCC_W'(drop_cnt);
  assign credit_ok = (occ < OCC_W'(DEPTH));

  // ---------------------------------------------------------------------------
  // Request side (purely combinational)
  // ---------------------------------------------------------------------------
  assign l1i_req_val_out  = ibuf_req_val_in & credit_ok & ~ibuf_kill_in;
  assign l1i_req_addr_out = ibuf_req_pc_in;
  assign ibuf_req_rdy_out = l1i_req_val_out & l1i_req_ack_in;

  // ---------------------------------------------------------------------------
  // Response classification
  // ---------------------------------------------------------------------------
  logic resp_drop;
  logic resp_keep;
  logic pend_push;
  logic pend_pop;
  logic ifq_push;
  logic ifq_pop;

  // Words belonging to killed requests come back first (in-order L1I), so
  // while drop_cnt is non-zero every response is one of those.
  assign resp_drop = l1i_resp_val_in & (drop_cnt != '0);
  // A response that arrives with nothing pending and nothing to drop is
  // spurious and simply ignored; a response in a kill cycle is never queued.
  assign resp_keep = l1i_resp_val_in & (drop_cnt == '0) & (pend_cnt != '0) & ~ibuf_kill_in;

  assign pend_push = ibuf_req_rdy_out;
  assign pend_pop  = resp_keep;
  assign ifq_push  = resp_keep;
  assign ifq_pop   = dec_val_out & dec_rdy_in & ~ibuf_kill_in;

  // ---------------------------------------------------------------------------
  // Pending-PC FIFO: PCs of acked requests awaiting their instruction word
  // ---------------------------------------------------------------------------
  logic [31:0]      pend_mem [DEPTH];
  logic [PTR_W-1:0] pend_wr;
  logic [PTR_W-1:0] pend_rd;
  logic [31:0]      pend_head;

  assign pend_head = pend_mem[pend_rd];

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_wr  <= '0;
      pend_rd  <= '0;
      pend_cnt <= '0;
    end else if (ibuf_kill_in) begin
      // In-flight requests are now tracked by drop_cnt instead.
      pend_wr  <= '0;
      pend_rd  <= '0;
      pend_cnt <= '0;
    end else begin
      if (pend_push) begin
        pend_wr <= pend_wr + PTR_W'(1);
      end
      if (pend_pop) begin
        pend_rd <= pend_rd + PTR_W'(1);
      end
      if (pend_push && !pend_pop) begin
        pend_cnt <= pend_cnt + CNT_W'(1);
      end else if (!pend_push && pend_pop) begin
        pend_cnt <= pend_cnt - CNT_W'(1);
      end
    end
  end

  // PC storage needs no reset: an entry is only read after it was written.
  always_ff @(posedge clk) begin
    if (!rst && !ibuf_kill_in && pend_push) begin
      pend_mem[pend_wr] <= ibuf_req_pc_in;
    end
  end

  // ---------------------------------------------------------------------------
  // Instruction FIFO: {instr, pc, pc+4} entries presented show-ahead to decode
  // ---------------------------------------------------------------------------
  ibuf_ent_t        ifq_mem [DEPTH];
  logic [PTR_W-1:0] ifq_wr;
  logic [PTR_W-1:0] ifq_rd;
  ibuf_ent_t        ifq_push_dat;
  ibuf_ent_t        ifq_head;

  always_comb begin
    ifq_push_dat       = '0;
    ifq_push_dat.instr = l1i_resp_data_in;
    ifq_push_dat.pc    = pend_head;
    ifq_push_dat.pc_4  = pend_head + 32'd4;  // wraps modulo 2^32
  end

  assign ifq_head = ifq_mem[ifq_rd];

  always_ff @(posedge clk) begin
    if (rst) begin
      ifq_wr  <= '0;
      ifq_rd  <= '0;
      ifq_cnt <= '0;
      // Storage is cleared so the decode outputs read as zero after reset.
      for (int i = 0; i < DEPTH; i++) begin
        ifq_mem[i] <= '0;
      end
    end else if (ibuf_kill_in) begin
      ifq_wr  <= '0;
      ifq_rd  <= '0;
      ifq_cnt <= '0;
    end else begin
      if (ifq_push) begin
        ifq_mem[ifq_wr] <= ifq_push_dat;
        ifq_wr          <= ifq_wr + PTR_W'(1);
      end
      if (ifq_pop) begin
        ifq_rd <= ifq_rd + PTR_W'(1);
      end
      if (ifq_push && !ifq_pop) begin
        ifq_cnt <= ifq_cnt + CNT_W'(1);
      end else if (!ifq_push && ifq_pop) begin
        ifq_cnt <= ifq_cnt - CNT_W'(1);
      end
    end
  end

  assign dec_val_out   = (ifq_cnt != '0);
  assign dec_instr_out = ifq_head.instr;
  assign dec_pc_out    = ifq_head.pc;
  assign dec_pc_4_out  = ifq_head.pc_4;

  // ---------------------------------------------------------------------------
  // Drop counter: responses still owed by the L1I for killed requests
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0] inflight;
  logic             kill_resp;

  // drop_cnt + pend_cnt never exceeds DEPTH, so this sum cannot wrap.
  assign inflight  = drop_cnt + pend_cnt;
  // A response arriving in the kill cycle retires one of the in-flight words;
  // a spurious one (nothing in flight) must not underflow the counter.
  assign kill_resp = l1i_resp_val_in & (inflight != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      drop_cnt <= '0;
    end else if (ibuf_kill_in) begin
      drop_cnt <= inflight - CNT_W'(kill_resp);
    end else if (resp_drop) begin
      drop_cnt <= drop_cnt - CNT_W'(1);
    end
  end

  // The L1I must never return a word that was not requested.
  a_no_spurious_resp: assert property (
    @(posedge clk) disable iff (rst)
      l1i_resp_val_in |-> ((drop_cnt != '0) || (pend_cnt != '0))
  );

endmodule

// File: tb/tb_core_if_ibuf.sv
// tb_core_if_ibuf: randomized and directed bench for core_if_ibuf with a queue-based reference model.
// The driver owns the L1I model and the expected-entry queue; a negedge monitor pops and compares.
// Credit is modelled as: expected queued entries + unanswered requests (killed or not) < DEPTH.
module tb_core_if_ibuf;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_val = 1'b0;
  logic [31:0] req_pc = '0;
  logic        kill = 1'b0;
  logic        ack = 1'b0;
  logic        resp_val = 1'b0;
  logic [31:0] resp_data = '0;
  logic        dec_rdy = 1'b0;

  logic        req_rdy;
  logic        l1i_val;
  logic [31:0] l1i_addr;
  logic        dec_val;
  logic [31:0] dec_instr;
  logic [31:0] dec_pc;
  logic [31:0] dec_pc4;

  always #5 clk = ~clk;

  core_if_ibuf #(.DEPTH(DEPTH)) dut (
    .clk              (clk),
    .rst              (rst),
    .ibuf_req_val_in  (req_val),
    .ibuf_req_pc_in   (req_pc),
    .ibuf_req_rdy_out (req_rdy),
    .ibuf_kill_in     (kill),
    .l1i_req_val_out  (l1i_val),
    .l1i_req_addr_out (l1i_addr),
    .l1i_req_ack_in   (ack),
    .l1i_resp_val_in  (resp_val),
    .l1i_resp_data_in (resp_data),
    .dec_val_out      (dec_val),
    .dec_instr_out    (dec_instr),
    .dec_pc_out       (dec_pc),
    .dec_pc_4_out     (dec_pc4),
    .dec_rdy_in       (dec_rdy)
  );

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc4;
  } ent_t;

  typedef struct {
    logic [31:0] pc;
    bit          killed;
  } req_t;

  ent_t exp_q[$];   // entries decode should see, in order
  req_t out_q[$];   // requests the L1I model still owes a word for

  int checks = 0;
  int failures = 0;
  bit last_acc = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: decode side, sampled away from the rising edge.
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      chk("dec_val", 32'(dec_val), 32'(exp_q.size() != 0));
      if (dec_val && dec_rdy && !kill) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL dec_pop: unexpected entry instr 0x%08h pc 0x%08h", dec_instr, dec_pc);
        end else begin
          ent_t e;
          e = exp_q.pop_front();
          chk("dec_instr", dec_instr, e.instr);
          chk("dec_pc", dec_pc, e.pc);
          chk("dec_pc_4", dec_pc4, e.pc4);
        end
      end
    end
  end

  // One clock cycle of stimulus; model effects are applied after the monitor
  // has sampled this cycle, which is equivalent to applying them at the edge.
  task automatic cyc(input bit r, input bit rv, input logic [31:0] pc, input bit ak,
                     input bit rs, input logic [31:0] rd, input bit kl, input bit dr);
    bit exp_acc;
    bit room;
    @(posedge clk);
    #1;
    rst = r; req_val = rv; req_pc = pc; ack = ak;
    resp_val = rs; resp_data = rd; kill = kl; dec_rdy = dr;
    #1;
    exp_acc  = 1'b0;
    last_acc = req_rdy;
    if (!r) begin
      room    = (exp_q.size() + out_q.size()) < DEPTH;
      exp_acc = rv && ak && !kl && room;
      chk("l1i_req_val", 32'(l1i_val), 32'(rv && !kl && room));
      chk("ibuf_req_rdy", 32'(req_rdy), 32'(exp_acc));
      if (l1i_val) chk("l1i_req_addr", l1i_addr, pc);
    end
    @(negedge clk);
    #1;
    if (r) begin
      exp_q.delete();
      out_q.delete();
    end else begin
      if (kl) begin
        exp_q.delete();
        foreach (out_q[i]) out_q[i].killed = 1'b1;
      end
      if (rs && out_q.size() != 0) begin
        req_t o;
        o = out_q.pop_front();
        if (!o.killed && !kl) exp_q.push_back('{rd, o.pc, o.pc + 32'd4});
      end
      if (exp_acc) out_q.push_back('{pc, 1'b0});
    end
  endtask

  task automatic idle(input int n, input bit dr);
    repeat (n) cyc(0, 0, 32'h0, 0, 0, 32'h0, 0, dr);
  endtask

  // Answer everything outstanding and let decode consume all entries.
  task automatic drain();
    int guard;
    guard = 0;
    while ((out_q.size() != 0 || exp_q.size() != 0) && guard < 200) begin
      cyc(0, 0, 32'h0, 0, out_q.size() != 0, $urandom, 0, 1);
      guard++;
    end
    chk("drain_empty", 32'(out_q.size() + exp_q.size()), 32'h0);
  endtask

  task automatic chk_dec(input string name, input logic [31:0] i, input logic [31:0] p, input logic [31:0] p4);
    chk({name, "_val"}, 32'(dec_val), 32'h1);
    chk({name, "_instr"}, dec_instr, i);
    chk({name, "_pc"}, dec_pc, p);
    chk({name, "_pc4"}, dec_pc4, p4);
  endtask

  initial begin
    int n;
    logic [31:0] pc;

    // Reset and reset state
    cyc(1, 0, 32'h0, 0, 0, 32'h0, 0, 0);
    cyc(1, 1, 32'h0, 1, 0, 32'h0, 0, 0);
    idle(1, 0);
    chk("rst_dec_val", 32'(dec_val), 32'h0);
    chk("rst_dec_instr", dec_instr, 32'h0);
    chk("rst_dec_pc", dec_pc, 32'h0);
    chk("rst_dec_pc4", dec_pc4, 32'h0);

    // Back-to-back stream, response one cycle after ack
    cyc(0, 1, 32'h200, 1, 0, 32'h0, 0, 1);
    cyc(0, 1, 32'h204, 1, 1, 32'hA0, 0, 1);
    cyc(0, 1, 32'h208, 1, 1, 32'hA1, 0, 1);
    chk_dec("stream0", 32'hA0, 32'h200, 32'h204);
    cyc(0, 0, 32'h0, 0, 1, 32'hA2, 0, 1);
    chk_dec("stream1", 32'hA1, 32'h204, 32'h208);
    idle(1, 1);
    chk_dec("stream2", 32'hA2, 32'h208, 32'h20C);
    idle(1, 1);
    chk("stream_empty", 32'(dec_val), 32'h0);

    // Backpressure: decode stalled until every slot is used
    cyc(0, 1, 32'h300, 1, 0, 32'h0, 0, 0);
    cyc(0, 1, 32'h304, 1, 1, 32'hD0, 0, 0);
    cyc(0, 1, 32'h308, 1, 1, 32'hD1, 0, 0);
    cyc(0, 1, 32'h30C, 1, 1, 32'hD2, 0, 0);
    cyc(0, 0, 32'h0, 0, 1, 32'hD3, 0, 0);
    cyc(0, 1, 32'h310, 1, 0, 32'h0, 0, 0);
    chk("bp_full_rdy", 32'(req_rdy), 32'h0);
    chk("bp_full_l1i_val", 32'(l1i_val), 32'h0);
    cyc(0, 1, 32'h310, 1, 0, 32'h0, 0, 1);
    chk("bp_pop_cycle_rdy", 32'(req_rdy), 32'h0);
    cyc(0, 1, 32'h310, 1, 0, 32'h0, 0, 0);
    chk("bp_after_pop_rdy", 32'(req_rdy), 32'h1);
    drain();

    // Kill with two outstanding and one queued
    cyc(0, 1, 32'h500, 1, 0, 32'h0, 0, 0);
    cyc(0, 1, 32'h504, 1, 1, 32'hE0, 0, 0);
    cyc(0, 1, 32'h508, 1, 0, 32'h0, 0, 0);
    cyc(0, 1, 32'h50C, 1, 0, 32'h0, 1, 1);
    chk("kill_blocks_req", 32'(l1i_val), 32'h0);
    idle(1, 1);
    chk("kill_dec_val", 32'(dec_val), 32'h0);
    cyc(0, 0, 32'h0, 0, 1, 32'hE1, 0, 1);
    cyc(0, 0, 32'h0, 0, 1, 32'hE2, 0, 1);
    cyc(0, 1, 32'h400, 1, 0, 32'h0, 0, 1);
    chk("kill_drop_dec_val", 32'(dec_val), 32'h0);
    cyc(0, 0, 32'h0, 0, 1, 32'hB0, 0, 0);
    idle(1, 0);
    chk_dec("kill_new", 32'hB0, 32'h400, 32'h404);
    drain();

    // Kill coinciding with a response, one other outstanding
    cyc(0, 1, 32'h600, 1, 0, 32'h0, 0, 1);
    cyc(0, 1, 32'h604, 1, 0, 32'h0, 0, 1);
    cyc(0, 0, 32'h0, 0, 1, 32'hF0, 1, 1);
    cyc(0, 0, 32'h0, 0, 1, 32'hF1, 0, 1);
    chk("killresp_dec_val0", 32'(dec_val), 32'h0);
    idle(1, 1);
    chk("killresp_dec_val1", 32'(dec_val), 32'h0);
    for (int i = 0; i < DEPTH; i++) begin
      cyc(0, 1, 32'h700 + 32'(4 * i), 1, 0, 32'h0, 0, 0);
      chk("killresp_credit", 32'(req_rdy), 32'h1);
    end
    drain();

    // PC+4 wrap, then pointer wrap over 3*DEPTH instructions
    cyc(0, 1, 32'hFFFF_FFFC, 1, 0, 32'h0, 0, 0);
    cyc(0, 0, 32'h0, 0, 1, 32'hC0, 0, 0);
    idle(1, 0);
    chk_dec("wrap", 32'hC0, 32'hFFFF_FFFC, 32'h0000_0000);
    drain();
    for (int i = 0; i < 3 * DEPTH; i++) begin
      cyc(0, 1, 32'h1000 + 32'(4 * i), 1, out_q.size() != 0, $urandom, 0, 1);
    end
    drain();

    // Reset mid-stream with two queued and two outstanding
    cyc(0, 1, 32'h800, 1, 0, 32'h0, 0, 0);
    cyc(0, 1, 32'h804, 1, 1, 32'h90, 0, 0);
    cyc(0, 1, 32'h808, 1, 1, 32'h91, 0, 0);
    cyc(0, 1, 32'h80C, 1, 0, 32'h0, 0, 0);
    cyc(1, 0, 32'h0, 0, 0, 32'h0, 0, 0);
    idle(1, 1);
    chk("mrst_dec_val", 32'(dec_val), 32'h0);
    chk("mrst_dec_instr", dec_instr, 32'h0);
    chk("mrst_dec_pc", dec_pc, 32'h0);
    chk("mrst_dec_pc4", dec_pc4, 32'h0);
    n = 0;
    for (int i = 0; i < DEPTH; i++) begin
      cyc(0, 1, 32'h900 + 32'(4 * i), 1, 0, 32'h0, 0, 0);
      if (req_rdy) n++;
    end
    chk("mrst_full_credit", 32'(n), 32'(DEPTH));
    drain();

    // Randomized traffic
    pc = 32'h2000;
    repeat (2000) begin
      bit rv, ak, rs, kl, dr;
      rv = $urandom_range(0, 9) < 7;
      ak = $urandom_range(0, 9) < 7;
      rs = (out_q.size() != 0) && ($urandom_range(0, 9) < 6);
      kl = $urandom_range(0, 49) == 0;
      dr = $urandom_range(0, 9) < 6;
      cyc(0, rv, pc, ak, rs, $urandom, kl, dr);
      if (last_acc) pc = pc + 32'd4;
      if (kl) pc = $urandom & 32'hFFFF_FFFC;
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/core_if_ibuf.md
Name: core_if_ibuf

Overview:
Instruction fetch buffer between the instruction fetch stage and the decode stage. It forwards fetch-stage PCs to the L1I cache, tracks outstanding L1I requests in order, and pairs each returning instruction word with its PC. The resulting {instr, pc, pc+4} entries are queued in a small FIFO for decode. It also throttles the fetch stage (drives its advance enable) and discards in-flight instructions on a pipeline kill (branch/jump redirect).

Parameters:
DEPTH, 4, total slots (queued instructions plus outstanding L1I requests); power of two, 2..16
CNT_W, $clog2(DEPTH)+1, width of the internal occupancy counters

Ports:
clk  in  1  core clock
rst  in  1  synchronous reset, active-high
ibuf_req_val_in  in  1  fetch stage has a PC to fetch
ibuf_req_pc_in  in  32  PC to fetch
ibuf_req_rdy_out  out  1  request accepted this cycle; fetch stage advances its PC (drives if_enb)
ibuf_kill_in  in  1  flush: drop all queued and in-flight instructions
l1i_req_val_out  out  1  L1I request valid
l1i_req_addr_out  out  32  L1I request address
l1i_req_ack_in  in  1  L1I accepts request this cycle
l1i_resp_val_in  in  1  L1I returns one instruction word (in request order)
l1i_resp_data_in  in  32  instruction word
dec_val_out  out  1  decode entry valid
dec_instr_out  out  32  instruction
dec_pc_out  out  32  PC of instruction
dec_pc_4_out  out  32  PC + 4
dec_rdy_in  in  1  decode consumes head entry when dec_val_out & dec_rdy_in

Behaviour:
- Interface: one clock clk; reset rst is synchronous and active-high.
- State: pending-PC FIFO (pend), instruction FIFO (ifq), both DEPTH entries; counters pend_cnt, ifq_cnt, drop_cnt.
- credit_ok = (ifq_cnt + pend_cnt + drop_cnt) < DEPTH.
- l1i_req_val_out = ibuf_req_val_in & credit_ok & ~ibuf_kill_in; l1i_req_addr_out = ibuf_req_pc_in. Both combinational.
- ibuf_req_rdy_out = l1i_req_val_out & l1i_req_ack_in. On that cycle, push ibuf_req_pc_in into pend.
- L1I response latency is >= 1 cycle after ack. Responses return strictly in request order.
- Response handling, when l1i_resp_val_in:
  - if drop_cnt > 0: decrement drop_cnt, no push.
  - else: pop pend head and push {data, pc, pc+4} into ifq.
  - pc+4 wraps modulo 2^32.
- Decode side is show-ahead. dec_val_out = (ifq_cnt != 0). Outputs reflect the ifq head. Pop on dec_val_out & dec_rdy_in.
- Response-to-decode latency: an entry written in cycle N is visible on dec_* in cycle N+1. There is no combinational bypass.
- Simultaneous push and pop on ifq: both take effect; ifq_cnt is unchanged. Overflow is impossible by credit construction.
- Full: credit_ok=0 forces ibuf_req_rdy_out=0 and l1i_req_val_out=0 until a decode pop or a drop frees a slot. Freed credit is usable in the next cycle.
- Kill (ibuf_kill_in=1), in that cycle:
  - no new request; ifq_cnt <= 0; pend_cnt <= 0; decode pop ignored.
  - drop_cnt <= drop_cnt + pend_cnt - l1i_resp_val_in. A response in the kill cycle is never queued.
  - dec_val_out = 0 from the next cycle.
  - A request may be issued in the cycle after kill.
- Spurious response with drop_cnt=0 and pend_cnt=0: ignored. Verification flags this with an assertion.
- Reset: all counters 0, FIFO pointers 0. Outputs after reset: dec_val_out=0, dec_instr_out=0, dec_pc_out=0, dec_pc_4_out=0, ibuf_req_rdy_out/l1i_req_val_out follow ibuf_req_val_in & l1i_req_ack_in. Reset mid-operation discards everything; the L1I is reset by the same rst.

Test Plan:
- Stream: PCs 0x200,0x204,0x208 acked back-to-back, responses 1 cycle later with data 0xA0,0xA1,0xA2, dec_rdy=1 -> dec outputs (0xA0,0x200,0x204),(0xA1,0x204,0x208),(0xA2,0x208,0x20C) on consecutive cycles, each 1 cycle after its response.
- Backpressure: dec_rdy=0, 4 requests acked, responses returned -> 5th request sees ibuf_req_rdy_out=0 and l1i_req_val_out=0. One dec pop -> request accepted the next cycle.
- Kill with 2 outstanding, 1 queued: kill -> dec_val_out=0 next cycle, drop_cnt=2. Two later responses discarded. New request for 0x400 (data 0xB0) -> dec shows (0xB0,0x400,0x404) only.
- Kill coinciding with a response and 1 other outstanding -> drop_cnt=1. The response is not queued and the next response is dropped.
- Wrap: PC 0xFFFFFFFC -> dec_pc_4_out=0x00000000. Run 3*DEPTH instructions to exercise FIFO pointer wrap with in-order output.
- rst asserted mid-stream with 2 outstanding and 2 queued -> next cycle dec_val_out=0, all dec_* outputs 0, full credit available (DEPTH requests accepted).
